// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: FU result requests in, grants and CDB broadcast slots out.
// The master side is the FU/consumer view; the slave side is the arbiter itself.
interface cdb_arbiter_if #(
  parameter int WORD_SIZE = 32,
  parameter int FU_NUM    = 8,
  parameter int FU_ID_W   = 3,
  parameter int RB_INDEX  = 4,
  parameter int CDB_PORTS = 2
);
  logic [FU_NUM-1:0]             fu_req;
  logic [FU_NUM*WORD_SIZE-1:0]   fu_data;
  logic [FU_NUM*RB_INDEX-1:0]    fu_rb_index;
  logic [FU_NUM-1:0]             fu_grant;
  logic [CDB_PORTS-1:0]          cdb_valid;
  logic [CDB_PORTS*WORD_SIZE-1:0] cdb_data;
  logic [CDB_PORTS*RB_INDEX-1:0] cdb_rb_index;
  logic [CDB_PORTS*FU_ID_W-1:0]  cdb_fu_id;

  modport master (
    output fu_req, fu_data, fu_rb_index,
    input  fu_grant, cdb_valid, cdb_data, cdb_rb_index, cdb_fu_id
  );

  modport slave (
    input  fu_req, fu_data, fu_rb_index,
    output fu_grant, cdb_valid, cdb_data, cdb_rb_index, cdb_fu_id
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to CDB_PORTS FU results per cycle onto registered CDB slots.
// Grants are combinational; the granted results appear on the CDB one cycle later.
module cdb_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int FU_NUM    = 8,
  parameter int FU_ID_W   = 3,
  parameter int RB_INDEX  = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  localparam logic [RB_INDEX-1:0] RB_NULL = '1;
  localparam logic [FU_ID_W:0]    FU_NUM_W = (FU_ID_W+1)'(FU_NUM);

  logic [FU_ID_W-1:0]                rr_ptr;
  logic [FU_ID_W-1:0]                rr_ptr_nxt;
  logic [FU_NUM-1:0]                 eligible;
  logic [FU_NUM-1:0]                 grant;
  logic [CDB_PORTS-1:0]              slot_vld;
  logic [CDB_PORTS-1:0][FU_ID_W-1:0] slot_fu;
  logic [WORD_SIZE-1:0]              fu_data_arr  [FU_NUM];
  logic [RB_INDEX-1:0]               fu_index_arr [FU_NUM];

  logic [FU_ID_W:0]   scan_sum;
  logic [FU_ID_W:0]   next_sum;
  logic [FU_ID_W-1:0] scan;
  int                 n_granted;

  always_comb begin
    for (int i = 0; i < FU_NUM; i++) begin
      fu_data_arr[i]  = bus.fu_data[i*WORD_SIZE +: WORD_SIZE];
      fu_index_arr[i] = bus.fu_rb_index[i*RB_INDEX +: RB_INDEX];
      eligible[i]     = bus.fu_req[i] && (fu_index_arr[i] != RB_NULL);
    end
  end

  // Scan from rr_ptr; the n-th eligible FU in scan order lands in slot n.
  always_comb begin
    grant      = '0;
    slot_vld   = '0;
    slot_fu    = '0;
    rr_ptr_nxt = rr_ptr;
    n_granted  = 0;
    scan_sum   = '0;
    next_sum   = '0;
    scan       = '0;
    if (reset && !flush) begin
      for (int off = 0; off < FU_NUM; off++) begin
        scan_sum = {1'b0, rr_ptr} + (FU_ID_W+1)'(off);
        if (scan_sum >= FU_NUM_W) begin
          scan_sum = scan_sum - FU_NUM_W;
        end
        scan = scan_sum[FU_ID_W-1:0];
        if (eligible[scan]) begin
          if (n_granted < CDB_PORTS) begin
            grant[scan] = 1'b1;
            for (int k = 0; k < CDB_PORTS; k++) begin
              if (k == n_granted) begin
                slot_vld[k] = 1'b1;
                slot_fu[k]  = scan;
              end
            end
            next_sum = {1'b0, scan} + 1'b1;
            if (next_sum >= FU_NUM_W) begin
              next_sum = '0;
            end
            rr_ptr_nxt = next_sum[FU_ID_W-1:0];
          end
          n_granted = n_granted + 1;
        end
      end
    end
  end

  assign bus.fu_grant = grant;

  // Flush suppresses all grants, so the slots load empty and the pointer holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr           <= '0;
      bus.cdb_valid    <= '0;
      bus.cdb_data     <= '0;
      bus.cdb_rb_index <= {CDB_PORTS{RB_NULL}};
      bus.cdb_fu_id    <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      for (int k = 0; k < CDB_PORTS; k++) begin
        bus.cdb_valid[k] <= slot_vld[k];
        if (slot_vld[k]) begin
          bus.cdb_data[k*WORD_SIZE +: WORD_SIZE]   <= fu_data_arr[slot_fu[k]];
          bus.cdb_rb_index[k*RB_INDEX +: RB_INDEX] <= fu_index_arr[slot_fu[k]];
          bus.cdb_fu_id[k*FU_ID_W +: FU_ID_W]      <= slot_fu[k];
        end else begin
          bus.cdb_data[k*WORD_SIZE +: WORD_SIZE]   <= '0;
          bus.cdb_rb_index[k*RB_INDEX +: RB_INDEX] <= RB_NULL;
          bus.cdb_fu_id[k*FU_ID_W +: FU_ID_W]      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors push expected CDB slots,
// a monitor pops and compares them one cycle after each grant edge.
module tb_cdb_arbiter;
  localparam int WORD_SIZE = 32;
  localparam int FU_NUM    = 8;
  localparam int FU_ID_W   = 3;
  localparam int RB_INDEX  = 4;
  localparam int CDB_PORTS = 2;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  cdb_arbiter_if #(
    .WORD_SIZE(WORD_SIZE), .FU_NUM(FU_NUM), .FU_ID_W(FU_ID_W),
    .RB_INDEX(RB_INDEX), .CDB_PORTS(CDB_PORTS)
  ) bus ();

  cdb_arbiter #(
    .WORD_SIZE(WORD_SIZE), .FU_NUM(FU_NUM), .FU_ID_W(FU_ID_W),
    .RB_INDEX(RB_INDEX), .CDB_PORTS(CDB_PORTS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  e_valid;
    logic [63:0] e_data;
    logic [7:0]  e_index;
    logic [5:0]  e_fu;
  } exp_t;

  exp_t        q[$];
  logic [31:0] dat [FU_NUM];
  logic [3:0]  rbi [FU_NUM];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < FU_NUM; i++) begin
      bus.fu_data[i*WORD_SIZE +: WORD_SIZE]   = dat[i];
      bus.fu_rb_index[i*RB_INDEX +: RB_INDEX] = rbi[i];
    end
  endtask

  task automatic check_cleared(input string name);
    check({name, " grant"},     64'(bus.fu_grant),     64'h0);
    check({name, " valid"},     64'(bus.cdb_valid),    64'h0);
    check({name, " rb_index"},  64'(bus.cdb_rb_index), 64'hFF);
    check({name, " data"},      bus.cdb_data,          64'h0);
    check({name, " fu_id"},     64'(bus.cdb_fu_id),    64'h0);
  endtask

  // Apply one cycle of requests; fu0/fu1 are the hand-computed FUs for slots 0/1.
  task automatic apply(input string name, input logic [7:0] req, input logic fl,
                       input logic [7:0] exp_g, input logic [1:0] exp_v,
                       input int fu0, input int fu1);
    exp_t e;
    int   fu;
    @(negedge clk);
    reset      = 1'b1;
    flush      = fl;
    bus.fu_req = req;
    drive_bus();
    #1;
    check({name, " grant"}, 64'(bus.fu_grant), 64'(exp_g));
    e.e_valid = exp_v;
    e.e_data  = '0;
    e.e_index = '0;
    e.e_fu    = '0;
    for (int k = 0; k < CDB_PORTS; k++) begin
      fu = (k == 0) ? fu0 : fu1;
      if (exp_v[k]) begin
        e.e_data[k*32 +: 32] = dat[fu];
        e.e_index[k*4 +: 4]  = rbi[fu];
        e.e_fu[k*3 +: 3]     = 3'(fu);
      end else begin
        e.e_index[k*4 +: 4]  = 4'hF;
      end
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cdb_valid",    64'(bus.cdb_valid),    64'(e.e_valid));
        check("cdb_data",     bus.cdb_data,          e.e_data);
        check("cdb_rb_index", 64'(bus.cdb_rb_index), 64'(e.e_index));
        check("cdb_fu_id",    64'(bus.cdb_fu_id),    64'(e.e_fu));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    reset      = 1'b0;
    flush      = 1'b0;
    bus.fu_req = '1;
    for (int i = 0; i < FU_NUM; i++) begin
      dat[i] = 32'hC0DE_0000 | 32'(i);
      rbi[i] = 4'(i);
    end
    drive_bus();
    repeat (2) @(posedge clk);
    #2;
    check_cleared("reset_hold");

    // first edge after release arbitrates from FU0
    apply("rst_release", 8'h03, 1'b0, 8'h03, 2'b11, 0, 1);    // ptr -> 2
    apply("idle",        8'h00, 1'b0, 8'h00, 2'b00, 0, 0);    // ptr 2
    dat[5] = 32'hDEAD_BEEF;
    rbi[5] = 4'd3;
    apply("single_fu5",  8'h20, 1'b0, 8'h20, 2'b01, 5, 0);    // ptr -> 6
    apply("wrap",        8'h84, 1'b0, 8'h84, 2'b11, 7, 2);    // ptr -> 3
    rbi[1] = 4'hF;
    rbi[4] = 4'd2;
    apply("null_idx_a",  8'h12, 1'b0, 8'h10, 2'b01, 4, 0);    // ptr -> 5
    apply("null_idx_b",  8'h12, 1'b0, 8'h10, 2'b01, 4, 0);    // ptr 5
    apply("flush",       8'h09, 1'b1, 8'h00, 2'b00, 0, 0);    // ptr 5
    apply("post_flush",  8'h09, 1'b0, 8'h09, 2'b11, 0, 3);    // ptr -> 4
    rbi[1] = 4'd1;
    apply("all_from_4",  8'hFF, 1'b0, 8'h30, 2'b11, 4, 5);    // ptr -> 6

    // asynchronous reset between edges with every FU requesting
    @(posedge clk);
    #2;
    reset      = 1'b0;
    bus.fu_req = '1;
    #1;
    check_cleared("reset_mid");

    apply("rr_01",  8'hFF, 1'b0, 8'h03, 2'b11, 0, 1);
    apply("rr_23",  8'hFF, 1'b0, 8'h0C, 2'b11, 2, 3);
    apply("rr_45",  8'hFF, 1'b0, 8'h30, 2'b11, 4, 5);
    apply("rr_67",  8'hFF, 1'b0, 8'hC0, 2'b11, 6, 7);
    apply("rr_01b", 8'hFF, 1'b0, 8'h03, 2'b11, 0, 1);
    apply("drain",  8'h00, 1'b0, 8'h00, 2'b00, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the common data bus (CDB) write ports among the functional units (FUs) of the out-of-order core. Each cycle it grants up to `CDB_PORTS` requesting FUs in round-robin order and registers their results, with reorder-buffer (RB) indices, onto the CDB output ports for one cycle. It sits between the FU result buses and the CDB data controller. It replaces the free-for-all per-FU write with a bounded, starvation-free broadcast.

## Interface

**Parameters**

- `WORD_SIZE`, 32, result width.
- `FU_NUM`, 8, number of requesting FUs.
- `FU_ID_W`, 3, width of an FU identifier; `2**FU_ID_W >= FU_NUM`.
- `RB_INDEX`, 4, RB index width. The all-ones value is NULL.
- `CDB_PORTS`, 2, CDB broadcast slots per cycle; `1 <= CDB_PORTS <= FU_NUM`.

**Ports**

- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `flush`, input, 1: synchronous pipeline flush.
- `fu_req`, input, `FU_NUM`: FU i has a result pending.
- `fu_data`, input, `FU_NUM*WORD_SIZE`: result of FU i at `[i*WORD_SIZE +: WORD_SIZE]`.
- `fu_rb_index`, input, `FU_NUM*RB_INDEX`: destination RB entry of FU i at `[i*RB_INDEX +: RB_INDEX]`.
- `fu_grant`, output, `FU_NUM`: combinational; the FU's result is accepted at this edge.
- `cdb_valid`, output, `CDB_PORTS`: registered; slot k carries a result.
- `cdb_data`, output, `CDB_PORTS*WORD_SIZE`: registered result for slot k.
- `cdb_rb_index`, output, `CDB_PORTS*RB_INDEX`: registered RB index for slot k. Reads NULL when the slot is invalid.
- `cdb_fu_id`, output, `CDB_PORTS*FU_ID_W`: registered source FU number for slot k.

## Operation

**Handshake**
- An FU raises `fu_req[i]` and holds its data and index stable until it samples `fu_grant[i]=1` at a rising edge.
- The FU may drop or retarget the request only after that edge.
- Dropping the request before a grant is allowed; nothing is recorded.

**Eligibility**
- FU i is eligible when `fu_req[i]=1` and its `fu_rb_index` is not NULL.
- A request carrying a NULL index is never granted.

**Arbitration (combinational)**
- State: round-robin pointer `rr_ptr`, range 0..`FU_NUM-1`.
- Scan FUs in order `rr_ptr, rr_ptr+1, …` modulo `FU_NUM`, visiting each once.
- The first `CDB_PORTS` eligible FUs are granted. The k-th granted FU in scan order maps to slot k, starting at 0.
- No FU is granted twice in one cycle, and no slot receives two FUs.

**Registered outputs (rising edge)**
- For each slot k that has a granted FU: `cdb_valid[k]=1`, and `cdb_data`, `cdb_rb_index`, `cdb_fu_id` take that FU's values.
- For each slot with no grant: `cdb_valid[k]=0`, `cdb_rb_index[k]`=NULL, `cdb_data[k]=0`, `cdb_fu_id[k]=0`.

**Pointer update**
- If any grant occurred, `rr_ptr <= (last granted FU + 1) mod FU_NUM`.
- If there was no grant, `rr_ptr` is unchanged.

**Flush**
- While `flush=1`, `fu_grant` is forced to 0.
- At the next edge all slots load the empty values (valid 0, index NULL, data 0, FU id 0).
- `rr_ptr` is unchanged.
- Pending requests remain pending; FUs are responsible for withdrawing them.

**Reset** (`reset=0`, asynchronous)
- `cdb_valid=0`, `cdb_rb_index`=all NULL, `cdb_data=0`, `cdb_fu_id=0`, `rr_ptr=0`.
- `fu_grant` is 0 while reset is asserted.
- Reset asserted mid-transfer discards the registered slots; granted results already captured are lost by design.

## Timing

- Grant latency is 0: `fu_grant[i]` is valid in the same cycle as the request when FU i is within the first `CDB_PORTS` eligible FUs from `rr_ptr`.
- Broadcast latency is 1: the result appears on the CDB in the cycle after the grant edge, for exactly one cycle, unless re-granted.
- Throughput: up to `CDB_PORTS` results per cycle.
- Fairness: a continuously eligible FU is granted within `ceil(FU_NUM/CDB_PORTS)` cycles.
- Back-to-back: an FU granted at edge N may request again for edge N+1. It competes normally, and the pointer has moved past it.
- The first edge after reset release arbitrates from FU 0.
- When `flush` and `reset` are both asserted, reset dominates.

## Test plan

All scenarios use the default parameters (`FU_NUM=8`, `CDB_PORTS=2`).

1. **Reset:** assert `reset=0` mid-run with all `fu_req=1` → outputs cleared immediately, all `cdb_rb_index=4'hF`. After release with FU0 and FU1 requesting, the first grants are FU0→slot0 and FU1→slot1.
2. **Single request:** FU5 requests with data `0xDEADBEEF`, index 3 → `fu_grant=8'h20` that cycle. Next cycle: `cdb_valid=2'b01`, slot0 data `0xDEADBEEF`, index 3, FU id 5; `rr_ptr` becomes 6.
3. **Round-robin:** all 8 FUs request continuously → grant pairs cycle through {0,1}, {2,3}, {4,5}, {6,7}, {0,1}. No FU waits more than 4 cycles.
4. **Wrap-around:** `rr_ptr=6` with FU7 and FU2 requesting → FU7→slot0, FU2→slot1; `rr_ptr` becomes 3.
5. **NULL index:** FU1 requests with index `4'hF`, FU4 requests with index 2 → only FU4 granted; FU1 is never granted while its index stays NULL.
6. **Flush:** flush asserted in the cycle where FU0 and FU3 request → `fu_grant=0`, next-cycle `cdb_valid=0`, `rr_ptr` unchanged. The requests are granted on the first cycle after flush deasserts.
